// File: rtl/mem_access.sv
// mem_access: load/store stage between execute and write-back.
// Non-memory results are registered through with one cycle of latency.
// Loads and stores run a valid/ack bus transaction while upstream is held.
// Load data is sign- or zero-extended before it is written back.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_instr_in,
  input  logic [4:0]  mem_write_addr_in,
  input  logic [31:0] mem_write_data_in,
  input  logic        mem_wen_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_store_data_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_wstrb_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic [4:0]  mem_write_addr_out,
  output logic [31:0] mem_write_data_out,
  output logic        mem_wen_out,
  output logic        mem_stall_out,
  output logic        mem_misalign_out,
  output logic        mem_bus_err_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  // Count value seen in the last BUSY cycle before the abort edge.
  localparam logic [31:0] TO_LAST  = TIMEOUT_CYCLES - 32'd1;

  // Load data extension: select the addressed byte/half and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wen_q, wen_d;
  logic        misalign_q, misalign_d;
  logic        err_q, err_d;
  logic        stall;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_load, is_store;
  logic        load_ok, store_ok, aligned;
  logic        mem_go, mem_misalign;
  logic        timeout_hit;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        unused_instr;

  assign opcode       = mem_instr_in[6:0];
  assign f3           = mem_instr_in[14:12];
  assign unused_instr = ^{mem_instr_in[31:15], mem_instr_in[11:7]};
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign load_ok      = is_load && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                    f3 == 3'd4 || f3 == 3'd5);
  assign store_ok     = is_store && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
  assign timeout_hit  = TO_EN && (cnt_q == TO_LAST);

  // Alignment check by access size (f3[1:0]: 0 byte, 1 half, 2 word).
  always_comb begin
    aligned = 1'b1;
    case (f3[1:0])
      2'd1:    aligned = (mem_addr_in[0] == 1'b0);
      2'd2:    aligned = (mem_addr_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign mem_go       = (load_ok || store_ok) && aligned;
  assign mem_misalign = (load_ok || store_ok) && !aligned;

  // Store lane formatting: replicate data across lanes and pick strobes.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = mem_store_data_in;
    case (f3[1:0])
      2'd0: begin
        st_wstrb = 4'b0001 << mem_addr_in[1:0];
        st_wdata = {4{mem_store_data_in[7:0]}};
      end
      2'd1: begin
        st_wstrb = 4'b0011 << {mem_addr_in[1], 1'b0};
        st_wdata = {2{mem_store_data_in[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = mem_store_data_in;
      end
    endcase
  end

  // Next-state, bus control, write-back and stall decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    is_store_d  = is_store_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wen_d       = 1'b0;
    misalign_d  = 1'b0;
    err_d       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        wb_addr_d = mem_write_addr_in;
        wb_data_d = mem_write_data_in;
        if (mem_go) begin
          stall       = 1'b1;
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_addr_in[31:2], 2'b00};
          bus_wstrb_d = is_store ? st_wstrb : 4'b0000;
          bus_wdata_d = is_store ? st_wdata : 32'd0;
          is_store_d  = is_store;
          f3_d        = f3;
          lane_d      = mem_addr_in[1:0];
          rd_d        = mem_write_addr_in;
        end else if (mem_misalign) begin
          misalign_d = 1'b1;
        end else if (!is_load && !is_store) begin
          // Unsupported load/store encodings fall through with wen low.
          wen_d = mem_wen_in;
        end
      end
      BUSY: begin
        if (bus_ack_in) begin
          // Ack beats a coincident timeout: normal completion.
          state_d   = IDLE;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          if (!is_store_q) begin
            wb_addr_d = rd_q;
            wb_data_d = load_extend(f3_q, lane_q, bus_rdata_in);
            wen_d     = (rd_q != 5'd0);
          end
        end else if (timeout_hit) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
        end else begin
          stall = 1'b1;
          if (TO_EN) cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      is_store_q  <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      rd_q        <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wen_q       <= 1'b0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      is_store_q  <= is_store_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wen_q       <= wen_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
    end
  end

  assign bus_req_out        = bus_req_q;
  assign bus_we_out         = bus_we_q;
  assign bus_addr_out       = bus_addr_q;
  assign bus_wdata_out      = bus_wdata_q;
  assign bus_wstrb_out      = bus_wstrb_q;
  assign mem_write_addr_out = wb_addr_q;
  assign mem_write_data_out = wb_data_q;
  assign mem_wen_out        = wen_q;
  assign mem_stall_out      = stall;
  assign mem_misalign_out   = misalign_q;
  assign mem_bus_err_out    = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for mem_access.
// Main instance uses a 4-cycle bus timeout; a second instance with no
// timeout shares all inputs.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in, wdata_in, addr_in, sdata_in, rdata_in;
  logic [4:0]  waddr_in;
  logic        wen_in, ack_in;

  logic        bus_req, bus_we, wen_out, stall, misalign, bus_err;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic [3:0]  bus_wstrb;
  logic [4:0]  wb_addr;

  logic        n_req, n_we, n_wen, n_stall, n_mis, n_err;
  logic [31:0] n_addr, n_wdata, n_data;
  logic [3:0]  n_wstrb;
  logic [4:0]  n_waddr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_instr_in(instr_in), .mem_write_addr_in(waddr_in),
    .mem_write_data_in(wdata_in), .mem_wen_in(wen_in),
    .mem_addr_in(addr_in), .mem_store_data_in(sdata_in),
    .bus_req_out(bus_req), .bus_we_out(bus_we), .bus_addr_out(bus_addr),
    .bus_wdata_out(bus_wdata), .bus_wstrb_out(bus_wstrb),
    .bus_ack_in(ack_in), .bus_rdata_in(rdata_in),
    .mem_write_addr_out(wb_addr), .mem_write_data_out(wb_data),
    .mem_wen_out(wen_out), .mem_stall_out(stall),
    .mem_misalign_out(misalign), .mem_bus_err_out(bus_err)
  );

  mem_access dut_nto (
    .clk(clk), .rst_n(rst_n),
    .mem_instr_in(instr_in), .mem_write_addr_in(waddr_in),
    .mem_write_data_in(wdata_in), .mem_wen_in(wen_in),
    .mem_addr_in(addr_in), .mem_store_data_in(sdata_in),
    .bus_req_out(n_req), .bus_we_out(n_we), .bus_addr_out(n_addr),
    .bus_wdata_out(n_wdata), .bus_wstrb_out(n_wstrb),
    .bus_ack_in(ack_in), .bus_rdata_in(rdata_in),
    .mem_write_addr_out(n_waddr), .mem_write_data_out(n_data),
    .mem_wen_out(n_wen), .mem_stall_out(n_stall),
    .mem_misalign_out(n_mis), .mem_bus_err_out(n_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    instr_in = 32'h0000_0013; waddr_in = 5'd0; wdata_in = 32'd0;
    wen_in = 1'b0; addr_in = 32'd0; sdata_in = 32'd0;
  endtask

  // Present one memory op, wait 'waits' BUSY cycles, then ack with rdata.
  task automatic mem_txn(input string tag, input logic [31:0] instr, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] sd, input int waits,
                         input logic [31:0] rdata, input logic exp_we,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    int stalls;
    stalls = 0;
    instr_in = instr; waddr_in = rd; wdata_in = 32'hCAFE_0000; wen_in = 1'b1;
    addr_in = addr; sdata_in = sd;
    #1;
    if (stall) stalls++;
    tick();
    set_nop();
    check({tag, " req"}, bus_req, 1'b1);
    check({tag, " addr"}, bus_addr, {addr[31:2], 2'b00});
    check({tag, " we"}, bus_we, exp_we);
    check({tag, " bubble"}, wen_out, 1'b0);
    if (exp_we) begin
      check({tag, " wstrb"}, bus_wstrb, exp_strb);
      check({tag, " wdata"}, bus_wdata, exp_wdata);
    end
    for (int i = 0; i < waits; i++) begin
      #1;
      if (stall) stalls++;
      tick();
    end
    ack_in = 1'b1; rdata_in = rdata;
    #1;
    check({tag, " stall@ack"}, stall, 1'b0);
    tick();
    ack_in = 1'b0;
    check({tag, " stall cycles"}, stalls, waits + 1);
    check({tag, " req drop"}, bus_req, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ack_in = 1'b0; rdata_in = 32'd0;
    set_nop();
    tick(); tick();
    rst_n = 1'b1;
    check("rst req", bus_req, 1'b0);
    check("rst addr", bus_addr, 32'd0);
    check("rst wstrb", bus_wstrb, 4'd0);
    check("rst wen", wen_out, 1'b0);
    check("rst wbdata", wb_data, 32'd0);
    check("rst flags", {misalign, bus_err}, 2'b00);

    // ADDI pass-through
    instr_in = mk(7'b0010011, 3'd0); waddr_in = 5'd5; wdata_in = 32'h10; wen_in = 1'b1;
    #1 check("addi stall", stall, 1'b0);
    tick();
    set_nop();
    check("addi wen", wen_out, 1'b1);
    check("addi rd", wb_addr, 5'd5);
    check("addi data", wb_data, 32'h10);
    check("addi stall2", stall, 1'b0);

    // LB / LBU lane 3, ack after 2 BUSY cycles
    mem_txn("lb", mk(7'b0000011, 3'd0), 5'd3, 32'h1003, 32'd0, 2, 32'h80AA_BBCC, 1'b0, 4'd0, 32'd0);
    check("lb wen", wen_out, 1'b1);
    check("lb rd", wb_addr, 5'd3);
    check("lb data", wb_data, 32'hFFFF_FF80);
    mem_txn("lbu", mk(7'b0000011, 3'd4), 5'd3, 32'h1003, 32'd0, 2, 32'h80AA_BBCC, 1'b0, 4'd0, 32'd0);
    check("lbu data", wb_data, 32'h0000_0080);

    // SH upper half, immediate ack
    mem_txn("sh", mk(7'b0100011, 3'd1), 5'd0, 32'h2002, 32'h1234_ABCD, 0, 32'd0, 1'b1, 4'b1100, 32'hABCD_ABCD);
    check("sh wen", wen_out, 1'b0);

    // SB lane 1 then LH/LHU upper half, back to back
    mem_txn("sb", mk(7'b0100011, 3'd0), 5'd0, 32'h3001, 32'h0000_00EF, 0, 32'd0, 1'b1, 4'b0010, 32'hEFEF_EFEF);
    mem_txn("lh", mk(7'b0000011, 3'd1), 5'd12, 32'h4002, 32'd0, 0, 32'h8001_1234, 1'b0, 4'd0, 32'd0);
    check("lh data", wb_data, 32'hFFFF_8001);
    mem_txn("lhu", mk(7'b0000011, 3'd5), 5'd12, 32'h4002, 32'd0, 1, 32'h8001_1234, 1'b0, 4'd0, 32'd0);
    check("lhu data", wb_data, 32'h0000_8001);

    // LW to x0: data written back but wen stays low
    mem_txn("lw0", mk(7'b0000011, 3'd2), 5'd0, 32'h4000, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
    check("lw0 data", wb_data, 32'hDEAD_BEEF);
    check("lw0 wen", wen_out, 1'b0);

    // Misaligned LW
    instr_in = mk(7'b0000011, 3'd2); waddr_in = 5'd4; wen_in = 1'b1; addr_in = 32'h2;
    #1 check("mis stall", stall, 1'b0);
    tick();
    set_nop();
    check("mis pulse", misalign, 1'b1);
    check("mis req", bus_req, 1'b0);
    check("mis wen", wen_out, 1'b0);
    tick();
    check("mis pulse end", misalign, 1'b0);

    // Unsupported load func3
    instr_in = mk(7'b0000011, 3'd3); waddr_in = 5'd4; wen_in = 1'b1; addr_in = 32'h0;
    #1 check("bad f3 stall", stall, 1'b0);
    tick();
    set_nop();
    check("bad f3 req", bus_req, 1'b0);
    check("bad f3 wen", wen_out, 1'b0);
    check("bad f3 flags", {misalign, bus_err}, 2'b00);

    // Timeout after 4 BUSY cycles; no-timeout instance keeps waiting
    instr_in = mk(7'b0000011, 3'd2); waddr_in = 5'd7; wen_in = 1'b1; addr_in = 32'h40;
    #1 check("to stall p", stall, 1'b1);
    tick();
    set_nop();
    check("to req b1", bus_req, 1'b1);
    tick(); tick(); tick();
    check("to req b4", bus_req, 1'b1);
    check("to stall b4", stall, 1'b0);
    check("nto stall b4", n_stall, 1'b1);
    tick();
    check("to req drop", bus_req, 1'b0);
    check("to err", bus_err, 1'b1);
    check("to wen", wen_out, 1'b0);
    check("nto req held", n_req, 1'b1);
    check("nto err", n_err, 1'b0);
    tick();
    check("to err end", bus_err, 1'b0);
    ack_in = 1'b1; rdata_in = 32'h1122_3344;
    tick();
    ack_in = 1'b0;
    check("nto wen", n_wen, 1'b1);
    check("nto data", n_data, 32'h1122_3344);
    check("idle ack ignored", wen_out, 1'b0);

    // Ack coinciding with the timeout cycle completes normally
    mem_txn("tie", mk(7'b0000011, 3'd2), 5'd8, 32'h44, 32'd0, 3, 32'h55, 1'b0, 4'd0, 32'd0);
    check("tie err", bus_err, 1'b0);
    check("tie wen", wen_out, 1'b1);
    check("tie data", wb_data, 32'h55);

    // Reset in BUSY, late ack ignored
    instr_in = mk(7'b0000011, 3'd2); waddr_in = 5'd9; wen_in = 1'b1; addr_in = 32'h50;
    tick();
    set_nop();
    check("rb req", bus_req, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rb req drop", bus_req, 1'b0);
    check("rb addr", bus_addr, 32'd0);
    check("rb wen", wen_out, 1'b0);
    rst_n = 1'b1;
    tick();
    ack_in = 1'b1; rdata_in = 32'h7777_7777;
    #1 check("rb stall", stall, 1'b0);
    tick();
    ack_in = 1'b0;
    check("rb late ack wen", wen_out, 1'b0);
    check("rb late ack req", bus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
